aes_host_sequencer: RTL

- Upstream host-side master for the 30-pin AES chip interface (address[3:0], data_in[15:0], data_out[7:0]).
- Accepts one job per handshake: key, block, mode and rekey flag.
- Sequences the chip's pin protocol: config, key load, init, ready poll, block load, next, valid poll, result readout.
- Returns the 128-bit result on a valid/ready output port; sits between the system bus logic and the AES pin interface.

---
 rtl/aes_host_sequencer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_host_sequencer.sv
// Host-side master for the 30-pin AES chip: turns one job handshake into the chip's
// config / key / init / block / next / readout pin sequence and returns the result block.
module aes_host_sequencer #(
    parameter int unsigned READ_LAT     = 1,
    parameter int unsigned POLL_TIMEOUT = 1023,
    parameter int unsigned TW           = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_key,
    input  logic         job_keylen,
    input  logic         job_encdec,
    input  logic         job_rekey,
    input  logic [127:0] job_block,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_data,
    output logic         res_err,
    output logic [3:0]   aes_address,
    output logic [15:0]  aes_data_in,
    input  logic [7:0]   aes_data_out,
    output logic         busy
);

    localparam int unsigned LW = $clog2(READ_LAT + 2);

    typedef enum logic [3:0] {
        StIdle, StCfg, StKeyCmd, StKeyData, StInit, StWaitRdy, StBlkCmd,
        StBlkData, StNext, StWaitVal, StResCmd, StResData, StDone
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    word_q, word_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [TW-1:0] poll_q, poll_d, poll_inc;
    logic [255:0]  key_q, key_d, key_sh;
    logic [127:0]  block_q, block_d, block_sh;
    logic          keylen_q, keylen_d;
    logic          encdec_q, encdec_d;
    logic          key_loaded_q, key_loaded_d;
    logic [127:0]  res_data_q, res_data_d;
    logic          res_err_q, res_err_d;
    logic [3:0]    addr_q, addr_d;
    logic [15:0]   din_q, din_d;
    logic          sample;

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        lat_d        = lat_q;
        poll_d       = poll_q;
        key_d        = key_q;
        block_d      = block_q;
        keylen_d     = keylen_q;
        encdec_d     = encdec_q;
        key_loaded_d = key_loaded_q;
        res_data_d   = res_data_q;
        res_err_d    = res_err_q;
        // Read data is usable once the address has been on the pins READ_LAT cycles.
        sample       = (lat_q == LW'(READ_LAT));
        poll_inc     = poll_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (job_valid) begin
                    key_d      = job_key;
                    block_d    = job_block;
                    keylen_d   = job_keylen;
                    encdec_d   = job_encdec;
                    res_data_d = '0;
                    res_err_d  = 1'b0;
                    state_d    = (job_rekey || !key_loaded_q) ? StCfg : StBlkCmd;
                end
            end
            StCfg:    state_d = StKeyCmd;
            StKeyCmd: begin
                state_d = StKeyData;
                word_d  = '0;
            end
            StKeyData: begin
                if (word_q == (keylen_q ? 4'd15 : 4'd7)) begin
                    state_d = StInit;
                    word_d  = '0;
                end else begin
                    word_d = word_q + 4'd1;
                end
            end
            StInit: begin
                state_d = StWaitRdy;
                lat_d   = '0;
                poll_d  = '0;
            end
            StWaitRdy: begin
                if (!sample) begin
                    lat_d = lat_q + 1'b1;
                end else if (aes_data_out[0]) begin
                    key_loaded_d = 1'b1;
                    state_d      = StBlkCmd;
                end else if (poll_inc == TW'(POLL_TIMEOUT)) begin
                    key_loaded_d = 1'b0;
                    res_err_d    = 1'b1;
                    res_data_d   = '0;
                    state_d      = StDone;
                end else begin
                    poll_d = poll_inc;
                end
            end
            StBlkCmd: begin
                state_d = StBlkData;
                word_d  = '0;
            end
            StBlkData: begin
                if (word_q == 4'd7) begin
                    state_d = StNext;
                    word_d  = '0;
                end else begin
                    word_d = word_q + 4'd1;
                end
            end
            StNext: begin
                state_d = StWaitVal;
                lat_d   = '0;
                poll_d  = '0;
            end
            StWaitVal: begin
                if (!sample) begin
                    lat_d = lat_q + 1'b1;
                end else if (aes_data_out[1]) begin
                    state_d = StResCmd;
                    lat_d   = '0;
                end else if (poll_inc == TW'(POLL_TIMEOUT)) begin
                    res_err_d  = 1'b1;
                    res_data_d = '0;
                    state_d    = StDone;
                end else begin
                    poll_d = poll_inc;
                end
            end
            StResCmd: begin
                state_d = StResData;
                word_d  = '0;
                if (!sample) lat_d = lat_q + 1'b1;
            end
            StResData: begin
                if (!sample) begin
                    lat_d = lat_q + 1'b1;
                end else begin
                    res_data_d = {res_data_q[119:0], aes_data_out};
                    if (word_q == 4'd15) begin
                        state_d = StDone;
                    end else begin
                        word_d = word_q + 4'd1;
                    end
                end
            end
            StDone: begin
                if (res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Pin values are derived from the next state so the registered pins line up with it.
    always_comb begin
        addr_d   = '0;
        din_d    = '0;
        key_sh   = key_q << {word_d, 4'b0000};
        block_sh = block_q << {word_d[2:0], 4'b0000};
        case (state_d)
            StCfg: begin
                addr_d = 4'd1;
                din_d  = {14'b0, keylen_d, encdec_d};
            end
            StKeyCmd:  addr_d = 4'd2;
            StKeyData: din_d = key_sh[255:240];
            StInit: begin
                addr_d = 4'd6;
                din_d  = 16'h0001;
            end
            StWaitRdy, StWaitVal: addr_d = 4'd5;
            StBlkCmd:  addr_d = 4'd3;
            StBlkData: din_d = block_sh[127:112];
            StNext: begin
                addr_d = 4'd6;
                din_d  = 16'h0002;
            end
            StResCmd:  addr_d = 4'd7;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            word_q       <= '0;
            lat_q        <= '0;
            poll_q       <= '0;
            key_q        <= '0;
            block_q      <= '0;
            keylen_q     <= 1'b0;
            encdec_q     <= 1'b0;
            key_loaded_q <= 1'b0;
            res_data_q   <= '0;
            res_err_q    <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            lat_q        <= lat_d;
            poll_q       <= poll_d;
            key_q        <= key_d;
            block_q      <= block_d;
            keylen_q     <= keylen_d;
            encdec_q     <= encdec_d;
            key_loaded_q <= key_loaded_d;
            res_data_q   <= res_data_d;
            res_err_q    <= res_err_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
        end
    end

    assign job_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign res_valid   = (state_q == StDone);
    assign res_data    = res_data_q;
    assign res_err     = res_err_q;
    assign aes_address = addr_q;
    assign aes_data_in = din_q;

endmodule
